// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped data cache.
// Exports: state_t (IDLE/WRITEBACK/ALLOCATE/UPDATE), BLOCK_W, WORD_W,
// OFFSET_BITS, INDEX_BITS, TAG_BITS and get_word() block word select.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, UPDATE} state_t;

  localparam int BLOCK_W     = 128;
  localparam int WORD_W      = 32;
  localparam int OFFSET_BITS = 2;
  localparam int INDEX_BITS  = 3;
  localparam int TAG_BITS    = 28 - INDEX_BITS;

  // Word 0 lives in block bits [31:0].
  function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] blk,
                                                 input logic [OFFSET_BITS-1:0] off);
    return blk[off*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU and data_memory signal bundle for the data cache.
// slave: cache controller view (CPU requests in, memory requests out).
// master: environment view (CPU + memory). hit_count/miss_count exist with DCACHE_STATS_EN.
interface dcache_if #(parameter int MEM_ADDR_W = 28);

  logic                  read;
  logic                  write;
  logic [31:0]           address;
  logic [31:0]           writedata;
  logic [31:0]           readdata;
  logic                  busywait;
  logic                  mem_read;
  logic                  mem_write;
  logic [MEM_ADDR_W-1:0] mem_address;
  logic [127:0]          mem_writedata;
  logic [127:0]          mem_readdata;
  logic                  mem_busywait;
`ifdef DCACHE_STATS_EN
  logic [31:0]           hit_count;
  logic [31:0]           miss_count;
`endif

  modport slave (
    input  read, write, address, writedata, mem_readdata, mem_busywait,
    output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
`ifdef DCACHE_STATS_EN
    , output hit_count, miss_count
`endif
  );

  modport master (
    output read, write, address, writedata, mem_readdata, mem_busywait,
    input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
`ifdef DCACHE_STATS_EN
    , input hit_count, miss_count
`endif
  );

endinterface

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays of the direct-mapped cache.
// Ports: clock, reset (sync active-low, clears valid+dirty), index selects the line
// for the combinational read port and the single write port (word write or line install).
module dcache_line_store import dcache_pkg::*; #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_W      = 25
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INDEX_BITS-1:0]  index,
  output logic                   line_valid,
  output logic                   line_dirty,
  output logic [TAG_W-1:0]       line_tag,
  output logic [BLOCK_W-1:0]     line_data,
  input  logic                   word_we,
  input  logic [OFFSET_BITS-1:0] word_offset,
  input  logic [WORD_W-1:0]      word_data,
  input  logic                   line_we,
  input  logic [TAG_W-1:0]       new_tag,
  input  logic [BLOCK_W-1:0]     new_data
);

  localparam int NLINES = 1 << INDEX_BITS;

  logic [NLINES-1:0]  valid_q;
  logic [NLINES-1:0]  dirty_q;
  logic [TAG_W-1:0]   tag_q  [NLINES];
  logic [BLOCK_W-1:0] data_q [NLINES];

  assign line_valid = valid_q[index];
  assign line_dirty = dirty_q[index];
  assign line_tag   = tag_q[index];
  assign line_data  = data_q[index];

  // Only the status bits are reset; tag/data are qualified by valid.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[index] <= 1'b1;
      dirty_q[index] <= 1'b0;
    end else if (word_we) begin
      dirty_q[index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && line_we) begin
      tag_q[index]  <= new_tag;
      data_q[index] <= new_data;
    end else if (reset && word_we) begin
      data_q[index][word_offset*WORD_W +: WORD_W] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back write-allocate data cache controller (FSM + handshake).
// Ports: clock, reset (sync active-low), bus (dcache_if.slave: CPU read/write/address/
// writedata/readdata/busywait, memory mem_* block handshake). Optional DCACHE_STATS_EN adds hit/miss counters.
module dcache_controller import dcache_pkg::*; #(
  parameter int INDEX_BITS = 3,
  parameter int MEM_ADDR_W = 28
) (
  input  logic     clock,
  input  logic     reset,
  dcache_if.slave  bus
);

  localparam int TAG_W = MEM_ADDR_W - INDEX_BITS;

  state_t                  state;
  logic [BLOCK_W-1:0]      refill_q;
  logic                    mem_read_q;
  logic                    mem_write_q;
  logic [MEM_ADDR_W-1:0]   mem_address_q;
  logic [BLOCK_W-1:0]      mem_writedata_q;

  logic [INDEX_BITS-1:0]   req_index;
  logic [OFFSET_BITS-1:0]  req_offset;
  logic [TAG_W-1:0]        req_tag;
  logic                    line_valid, line_dirty;
  logic [TAG_W-1:0]        line_tag;
  logic [BLOCK_W-1:0]      line_data;
  logic                    access, hit, in_idle, miss;
  logic                    unused_addr_bits;

  assign req_offset = bus.address[3:2];
  assign req_index  = bus.address[4 +: INDEX_BITS];
  assign req_tag    = bus.address[31:4+INDEX_BITS];
  assign unused_addr_bits = ^bus.address[1:0];

  // read && write together is not an access at all.
  assign access  = bus.read ^ bus.write;
  assign hit     = line_valid && (line_tag == req_tag);
  assign in_idle = (state == IDLE);
  assign miss    = in_idle && access && !hit;

  // CPU-side outputs are forced low while reset is held.
  assign bus.busywait = reset && (!in_idle || miss);
  assign bus.readdata = (reset && in_idle && bus.read && !bus.write && hit)
                        ? get_word(line_data, req_offset) : '0;

  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_address   = mem_address_q;
  assign bus.mem_writedata = mem_writedata_q;

  dcache_line_store #(.INDEX_BITS(INDEX_BITS), .TAG_W(TAG_W)) u_store (
    .clock       (clock),
    .reset       (reset),
    .index       (req_index),
    .line_valid  (line_valid),
    .line_dirty  (line_dirty),
    .line_tag    (line_tag),
    .line_data   (line_data),
    .word_we     (reset && in_idle && bus.write && !bus.read && hit),
    .word_offset (req_offset),
    .word_data   (bus.writedata),
    .line_we     (reset && (state == UPDATE)),
    .new_tag     (req_tag),
    .new_data    (refill_q)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= IDLE;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      refill_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            if (line_valid && line_dirty) begin
              state           <= WRITEBACK;
              mem_write_q     <= 1'b1;
              mem_address_q   <= {line_tag, req_index};
              mem_writedata_q <= line_data;
            end else begin
              state         <= ALLOCATE;
              mem_read_q    <= 1'b1;
              mem_address_q <= bus.address[31:32-MEM_ADDR_W];
            end
          end
        end
        WRITEBACK: begin
          // Enter ALLOCATE with mem_read still low for one cycle so the
          // memory sees its request drop and restarts cleanly.
          if (!bus.mem_busywait) begin
            state           <= ALLOCATE;
            mem_write_q     <= 1'b0;
            mem_writedata_q <= '0;
            mem_address_q   <= bus.address[31:32-MEM_ADDR_W];
          end
        end
        ALLOCATE: begin
          if (!mem_read_q) begin
            mem_read_q <= 1'b1;
          end else if (!bus.mem_busywait) begin
            state         <= UPDATE;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            refill_q      <= bus.mem_readdata;
          end
        end
        UPDATE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic        refilled_q;
  logic [31:0] hit_q, miss_q;

  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;

  // refilled_q marks the IDLE cycle right after UPDATE, whose re-hit is
  // part of the miss already counted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      refilled_q <= 1'b0;
      hit_q      <= '0;
      miss_q     <= '0;
    end else begin
      refilled_q <= (state == UPDATE);
      if (in_idle && access && hit && !refilled_q && hit_q != 32'hFFFF_FFFF)
        hit_q <= hit_q + 32'd1;
      if (miss && miss_q != 32'hFFFF_FFFF)
        miss_q <= miss_q + 32'd1;
    end
  end
`endif

endmodule
